// File: rtl/voice_recorder_pkg.sv
// Shared types and helpers for the voice recorder: FSM state encoding,
// default sample width and the stereo-to-mono mix.
package voice_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  localparam int SAMPLE_W_DEF = 16;

  // (l + r) >>> 1 on sign-extended operands; the caller truncates to its
  // sample width. Averaging two in-range samples cannot overflow.
  function automatic logic signed [31:0] mono_mix(input logic signed [31:0] l,
                                                  input logic signed [31:0] r);
    return (l + r) >>> 1;
  endfunction

endpackage

// File: rtl/recorder_ram.sv
// Single-port synchronous sample buffer, read-first, 1-cycle read latency.
// Kept in the plain registered-read form so synthesis maps it to block RAM.
module recorder_ram #(
  parameter int ADDR_W   = 12,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [2**ADDR_W];

  // write on we, always register the addressed word
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/voice_recorder.sv
// Voice recorder: captures mono-mixed codec record frames into an on-chip
// buffer and plays them back one sample per playback frame.
// Optional build macro VOICE_RECORDER_LOOP_EN: playback wraps to the start
// of the clip instead of stopping after one pass.
module voice_recorder
  import voice_recorder_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       record_button,
  input  logic                       play_button,
  input  logic signed [SAMPLE_W-1:0] rec_left,
  input  logic signed [SAMPLE_W-1:0] rec_right,
  input  logic                       rec_valid,
  input  logic                       new_frame,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       recording,
  output logic                       playing,
  output logic [ADDR_W:0]            rec_length
);

  localparam int             DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] ONE_L = (ADDR_W+1)'(1);

  state_t                     state, state_n;
  logic [ADDR_W-1:0]          wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, ram_addr;
  logic [ADDR_W:0]            rec_len_n, wr_cnt;
  logic signed [SAMPLE_W-1:0] sample_n, mix;
  logic [SAMPLE_W-1:0]        rdata;
  logic                       we, rd_pend, rd_pend_n, fin, fin_n, is_last;
`ifndef VOICE_RECORDER_LOOP_EN
  logic                       last_pend, last_n;
`endif

  assign mix     = SAMPLE_W'(mono_mix(32'(rec_left), 32'(rec_right)));
  // samples held after this cycle's write, used when recording stops
  assign wr_cnt  = {1'b0, wr_ptr} + {{ADDR_W{1'b0}}, rec_valid};
  assign is_last = ({1'b0, rd_ptr} == rec_length - ONE_L);

  recorder_ram #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (ram_addr),
    .wdata (mix),
    .rdata (rdata)
  );

  // next-state and datapath control
  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    rec_len_n = rec_length;
    sample_n  = sample_out;
    rd_pend_n = 1'b0;
    fin_n     = fin;
    we        = 1'b0;
    ram_addr  = rd_ptr;
`ifndef VOICE_RECORDER_LOOP_EN
    last_n    = last_pend;
`endif
    case (state)
      IDLE: begin
        sample_n = '0;
        if (record_button) begin
          state_n   = RECORD;
          wr_ptr_n  = '0;
          rec_len_n = '0;  // old clip is being overwritten
        end else if (play_button && rec_length != '0) begin
          state_n  = PLAY;
          rd_ptr_n = '0;
          fin_n    = 1'b0;
`ifndef VOICE_RECORDER_LOOP_EN
          last_n   = 1'b0;
`endif
        end
      end
      RECORD: begin
        sample_n = '0;
        ram_addr = wr_ptr;
        if (rec_valid) begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + ADDR_W'(1);
        end
        // manual stop counts a same-cycle sample; full buffer stops itself
        if (record_button || wr_cnt == (ADDR_W+1)'(DEPTH)) begin
          state_n   = IDLE;
          rec_len_n = wr_cnt;
        end
      end
      PLAY: begin
        if (play_button || fin) begin
          state_n  = IDLE;
          sample_n = '0;
          fin_n    = 1'b0;
        end else begin
          if (rd_pend) begin
            sample_n = rdata;
`ifndef VOICE_RECORDER_LOOP_EN
            if (last_pend) fin_n = 1'b1;  // leave one cycle after presenting
`endif
          end
`ifdef VOICE_RECORDER_LOOP_EN
          if (new_frame) begin
            rd_pend_n = 1'b1;
            rd_ptr_n  = is_last ? '0 : rd_ptr + ADDR_W'(1);
          end
`else
          if (new_frame && !last_pend) begin
            rd_pend_n = 1'b1;
            last_n    = is_last;
            rd_ptr_n  = rd_ptr + ADDR_W'(1);
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and datapath registers; status flags are registered decodes
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rec_length <= '0;
      sample_out <= '0;
      rd_pend    <= 1'b0;
      fin        <= 1'b0;
      recording  <= 1'b0;
      playing    <= 1'b0;
`ifndef VOICE_RECORDER_LOOP_EN
      last_pend  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      rec_length <= rec_len_n;
      sample_out <= sample_n;
      rd_pend    <= rd_pend_n;
      fin        <= fin_n;
      recording  <= (state_n == RECORD);
      playing    <= (state_n == PLAY);
`ifndef VOICE_RECORDER_LOOP_EN
      last_pend  <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_voice_recorder.sv
// Scoreboard bench for voice_recorder (ADDR_W=3, DEPTH=8). Stimulus pushes
// the expected playback sample for each armed new_frame; a monitor pops and
// compares two clocks after the pulse is sampled.
module tb_voice_recorder;
  logic               clk = 1'b0, reset = 1'b1;
  logic               record_button = 1'b0, play_button = 1'b0;
  logic signed [15:0] rec_left = '0, rec_right = '0;
  logic               rec_valid = 1'b0, new_frame = 1'b0;
  logic signed [15:0] sample_out;
  logic               recording, playing;
  logic [3:0]         rec_length;

  int                 n_chk = 0, n_pass = 0;
  logic signed [15:0] exp_q[$];
  bit                 arm = 1'b0, nf_d1 = 1'b0, nf_d2 = 1'b0;

  voice_recorder #(.ADDR_W(3), .SAMPLE_W(16)) dut (
    .clk(clk), .reset(reset), .record_button(record_button),
    .play_button(play_button), .rec_left(rec_left), .rec_right(rec_right),
    .rec_valid(rec_valid), .new_frame(new_frame), .sample_out(sample_out),
    .recording(recording), .playing(playing), .rec_length(rec_length)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic press_rec();  record_button = 1'b1; tick(); record_button = 1'b0; endtask
  task automatic press_play(); play_button = 1'b1; tick(); play_button = 1'b0; endtask

  task automatic rec_sample(input int l, input int r);
    rec_left = 16'(l); rec_right = 16'(r); rec_valid = 1'b1;
    tick(); rec_valid = 1'b0; repeat (2) tick();
  endtask

  task automatic frame(input bit arm_i, input int exp_v);
    if (arm_i) exp_q.push_back(16'(exp_v));
    arm = arm_i; new_frame = 1'b1;
    tick(); new_frame = 1'b0; arm = 1'b0;
  endtask

  // delay line marking when an armed frame's sample must be on sample_out
  always @(posedge clk) begin
    nf_d1 <= new_frame & arm;
    nf_d2 <= nf_d1;
  end

  // monitor: pop and compare
  initial begin
    logic signed [15:0] e;
    forever begin
      @(posedge clk); #1;
      if (nf_d2) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sample_out: got %0d with no expected sample queued", sample_out);
        end else begin
          e = exp_q.pop_front();
          check("sample_out", sample_out, e);
        end
      end
    end
  end

  initial begin
    int l_tab [5] = '{100, -200, 32767, -32768, 1};
    int r_tab [5] = '{300, -400, 32767, -32768, -2};
    int m_tab [5] = '{200, -300, 32767, -32768, -1};

    // reset state
    repeat (2) tick(); reset = 1'b0;
    check("rst_sample_out", sample_out, 0);
    check("rst_recording", recording, 0);
    check("rst_playing", playing, 0);
    check("rst_rec_length", rec_length, 0);

    // record and play back
    press_rec();
    check("rec_start", recording, 1);
    for (int i = 0; i < 5; i++) rec_sample(l_tab[i], r_tab[i]);
    press_rec();
    check("rec_stop_recording", recording, 0);
    check("rec_stop_length", rec_length, 5);
    press_play();
    check("play_start", playing, 1);
    for (int i = 0; i < 5; i++) begin frame(1'b1, m_tab[i]); repeat (49) tick(); end
    check("play_end_playing", playing, 0);
    check("play_end_sample", sample_out, 0);

    // auto-stop at full: 10 pulses, only 8 stored
    press_rec();
    for (int k = 1; k <= 10; k++) begin
      rec_sample(k * 10, k * 10);
      check("full_recording", recording, (k < 8) ? 1 : 0);
    end
    check("full_rec_length", rec_length, 8);
    press_play();
    for (int k = 1; k <= 8; k++) begin frame(1'b1, k * 10); repeat (9) tick(); end
    check("full_play_end", playing, 0);

    // ignored and priority buttons
    reset = 1'b1; tick(); reset = 1'b0;
    press_play();
    check("play_empty_ignored", playing, 0);
    record_button = 1'b1; play_button = 1'b1; tick();
    record_button = 1'b0; play_button = 1'b0;
    check("both_rec_wins", recording, 1);
    check("both_not_playing", playing, 0);
    press_play();
    check("play_in_rec_recording", recording, 1);
    check("play_in_rec_playing", playing, 0);
    for (int k = 1; k <= 5; k++) rec_sample(k * 11, k * 11);
    press_rec();
    check("clip2_length", rec_length, 5);

    // abort mid-play: second sample must never appear
    press_play();
    frame(1'b1, 11); repeat (49) tick();
    frame(1'b1, 0);
    press_play();
    check("abort_playing", playing, 0);
    check("abort_sample", sample_out, 0);
    repeat (3) tick();

    // reset mid-record discards the clip
    press_rec();
    for (int k = 1; k <= 3; k++) rec_sample(k, k);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rstrec_length", rec_length, 0);
    check("rstrec_recording", recording, 0);
    press_play();
    check("rstrec_play_ignored", playing, 0);

    // 3-sample clip, 7 frames
    press_rec();
    for (int k = 7; k <= 9; k++) rec_sample(k, k);
    press_rec();
    check("clip3_length", rec_length, 3);
    press_play();
`ifdef VOICE_RECORDER_LOOP_EN
    for (int i = 0; i < 7; i++) begin frame(1'b1, 7 + (i % 3)); repeat (19) tick(); end
    check("loop_playing", playing, 1);
    press_play();
    check("loop_stop", playing, 0);
`else
    for (int i = 0; i < 7; i++) begin frame(i < 3, 7 + (i % 3)); repeat (19) tick(); end
    check("oneshot_playing", playing, 0);
    check("oneshot_sample", sample_out, 0);
`endif

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/voice_recorder.md
Name: voice_recorder

Overview:
- Consumes the codec's record path: PCM_Record_Left, PCM_Record_Right and PCM_Record_Valid.
- Mixes each stereo pair to mono and stores it in an on-chip sample buffer.
- Plays the clip back on the playback path, one sample per new_frame pulse.
- Sits beside music_player; top level muxes sample_out into the codec playback inputs.

Parameters:
- ADDR_W, 12, buffer address width; DEPTH = 2**ADDR_W samples.
- SAMPLE_W, 16, PCM sample width, signed two's complement.

Ports:
- clk  in  1  system clock, same as codec interface clock
- reset  in  1  synchronous, active-high reset
- record_button  in  1  one-cycle pulse, already debounced; start/stop recording
- play_button  in  1  one-cycle pulse; start/stop playback
- rec_left  in  SAMPLE_W  codec PCM_Record_Left
- rec_right  in  SAMPLE_W  codec PCM_Record_Right
- rec_valid  in  1  codec PCM_Record_Valid, one-cycle pulse per captured frame
- new_frame  in  1  codec PCM_Playback_Accept, one-cycle pulse per playback frame
- sample_out  out  SAMPLE_W  mono playback sample
- recording  out  1  high while in RECORD
- playing  out  1  high while in PLAY
- rec_length  out  ADDR_W+1  number of valid stored samples, 0..DEPTH

Behaviour:
- Reset values, one clk after reset high:
  - state=IDLE; sample_out=0; recording=0; playing=0; rec_length=0; write and read pointers=0.
  - Reset mid-record or mid-play discards the clip: rec_length=0.
  - Buffer contents are not cleared.
- Mono mix: 17-bit signed sum of rec_left and rec_right, arithmetic shift right by 1, truncate to SAMPLE_W. No saturation is needed.
- FSM IDLE:
  - record_button -> RECORD, wr_ptr=0.
  - Else play_button with rec_length!=0 -> PLAY, rd_ptr=0.
  - play_button with rec_length==0 is ignored.
  - Simultaneous record_button and play_button: record wins.
- FSM RECORD:
  - Each rec_valid writes mix to buf[wr_ptr] and increments wr_ptr.
  - record_button -> IDLE with rec_length=wr_ptr. If rec_valid arrives in the same cycle, that sample is written and counted.
  - Write of address DEPTH-1 -> IDLE automatically with rec_length=DEPTH.
  - play_button is ignored.
- FSM PLAY:
  - On new_frame, read buf[rd_ptr]; buffer read latency is 1 cycle.
  - sample_out is registered and updates exactly 2 clk after the new_frame pulse, then holds until the next update.
  - rd_ptr increments per new_frame.
  - After issuing the read of index rec_length-1 -> IDLE once that sample has been presented.
  - play_button -> IDLE immediately, discarding any in-flight read.
  - record_button is ignored; rec_valid is ignored.
- sample_out is forced to 0 on entry to IDLE or RECORD.
- recording and playing are registered decodes of state, never both high.
- rec_valid and new_frame are asynchronous to each other. Each pulse is acted on only in its own state; no pulse is lost or double-counted in that state.

Optional Feature:
- Macro: VOICE_RECORDER_LOOP_EN.
- Defined: in PLAY, after index rec_length-1, rd_ptr wraps to 0 and playback continues until play_button or reset.
- Undefined: playback stops after one pass as described above.
- playing stays high across wrap; no gap frame is inserted.

Decomposition:
- Package voice_recorder_pkg:
  - state encoding IDLE=2'd0, RECORD=2'd1, PLAY=2'd2;
  - SAMPLE_W default;
  - mono-mix function.
- Sub-module recorder_ram: simple single-port synchronous RAM, DEPTH x SAMPLE_W, with we, addr, wdata, rdata and 1-cycle read latency. Record and play are mutually exclusive, so one port suffices. Write it in a form that infers block RAM.

Test Plan:
- Record and play back:
  - Stimulus: reset; record_button; 5 rec_valid pulses with (L,R)=(100,300),(−200,−400),(32767,32767),(−32768,−32768),(1,−2); record_button.
  - Required: rec_length=5, recording falls 1 clk after the button.
  - Stimulus: play_button, then 5 new_frame pulses 50 clk apart.
  - Required: sample_out = 200, −300, 32767, −32768, −1, each 2 clk after its pulse; then playing=0 and sample_out=0.
- Auto-stop at full:
  - Stimulus: ADDR_W=3; record_button; 10 rec_valid pulses.
  - Required: recording drops after the 8th; rec_length=8; pulses 9-10 are not written.
- Ignored and priority buttons:
  - play_button with rec_length=0 -> remains IDLE.
  - record_button and play_button in the same cycle from IDLE -> RECORD.
  - play_button during RECORD -> no effect.
- Abort mid-play:
  - Stimulus: play a 5-sample clip; play_button 1 clk after the 2nd new_frame.
  - Required: IDLE next cycle; sample_out=0; the 2nd sample is never presented.
- Reset mid-record:
  - Stimulus: 3 samples recorded; reset for 1 clk.
  - Required: rec_length=0; recording=0; subsequent play_button ignored.
- Loop:
  - Stimulus: with VOICE_RECORDER_LOOP_EN, 3-sample clip, 7 new_frame pulses.
  - Required: outputs s0,s1,s2,s0,s1,s2,s0; playing stays 1.
  - Without the macro: stops after s2.
